// File: rtl/piso.sv
// Parallel-in serial-out transmitter: 70-bit words shifted MSB-first with a one-word holding
// register for gap-free streaming. Define PISO_PARITY_EN to append an even-parity bit per word.
module piso #(
  parameter int unsigned WIDTH = 70,
  parameter int unsigned ROWS  = 14,
  parameter int unsigned RW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             dout,
  output logic             dvalid,
  output logic [RW-1:0]    row,
  output logic             done
);

  localparam logic [6:0]    BcntLast = 7'(WIDTH - 1);
  localparam logic [RW-1:0] RowLast  = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [6:0]       bcnt_q, bcnt_d;
  logic [RW-1:0]    row_q, row_d;
  logic             done_q, done_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  logic word_end;
  logic xfer;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    bcnt_d      = bcnt_q;
    row_d       = row_q;
    done_d      = 1'b0;
`ifdef PISO_PARITY_EN
    par_d       = par_q;
`endif
    word_end    = 1'b0;
    xfer        = 1'b0;

    unique case (state_q)
      StIdle: begin
        xfer = hold_full_q;
      end
      StShift: begin
        if (en) begin
          shreg_d = shreg_q << 1;
          if (bcnt_q != 7'd0) begin
            bcnt_d = bcnt_q - 7'd1;
          end else begin
`ifdef PISO_PARITY_EN
            state_d = StParity;
`else
            word_end = 1'b1;
`endif
          end
        end
      end
`ifdef PISO_PARITY_EN
      StParity: begin
        word_end = en;
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase

    // A finished word either chains straight into the held word or drops back to idle.
    if (word_end) begin
      row_d  = (row_q == RowLast) ? '0 : row_q + RW'(1);
      done_d = (row_q == RowLast);
      if (hold_full_q) begin
        xfer = 1'b1;
      end else begin
        state_d = StIdle;
      end
    end

    if (xfer) begin
      shreg_d     = hold_q;
      hold_full_d = 1'b0;
      bcnt_d      = BcntLast;
      state_d     = StShift;
`ifdef PISO_PARITY_EN
      par_d       = ^hold_q;
`endif
    end

    // Accept only into an empty holder, so this never collides with the transfer above.
    if (load && !hold_full_q) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      bcnt_q      <= '0;
      row_q       <= '0;
      done_q      <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      bcnt_q      <= bcnt_d;
      row_q       <= row_d;
      done_q      <= done_d;
`ifdef PISO_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  always_comb begin
    dout = 1'b0;
    unique case (state_q)
      StShift: dout = shreg_q[WIDTH-1];
`ifdef PISO_PARITY_EN
      StParity: dout = par_q;
`endif
      default: dout = 1'b0;
    endcase
  end

  assign ready  = !hold_full_q;
  assign dvalid = en && (state_q != StIdle);
  assign row    = row_q;
  assign done   = done_q;

endmodule

// File: tb/tb_piso.sv
// Self-checking bench for piso: cycle-level behavioural model (word/bit-index view) compared
// every cycle, plus literal checks on bit counts, stream contents, row and done.
module tb_piso;

  localparam int W = 70;
  localparam int R = 14;
  localparam int RWID = 4;
`ifdef PISO_PARITY_EN
  localparam int WL = W + 1;
  localparam int LAST = -1;
`else
  localparam int WL = W;
  localparam int LAST = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic            load = 1'b0;
  logic [W-1:0]    din = '0;
  logic            ready;
  logic            dout;
  logic            dvalid;
  logic [RWID-1:0] row;
  logic            done;

  piso #(.WIDTH(W), .ROWS(R), .RW(RWID)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (load),
    .din   (din),
    .ready (ready),
    .dout  (dout),
    .dvalid(dvalid),
    .row   (row),
    .done  (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: holder, current word with index of the bit on the line, frame position.
  bit           m_full;
  logic [W-1:0] m_hold;
  bit           m_busy;
  logic [W-1:0] m_word;
  int           m_idx;
  int           m_row;
  bit           m_done;

  int dv_cnt, rdy_low, run, maxrun, done_cnt;
  bit sq[$];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic model_reset();
    m_full = 0; m_hold = '0; m_busy = 0; m_word = '0; m_idx = 0; m_row = 0; m_done = 0;
  endtask

  task automatic clear_stats();
    dv_cnt = 0; rdy_low = 0; run = 0; maxrun = 0; done_cnt = 0;
    sq.delete();
  endtask

  task automatic check_cycle();
    logic e_dout;
    e_dout = 1'b0;
    if (m_busy) e_dout = (m_idx >= 0) ? m_word[m_idx] : ^m_word;
    chk("ready", ready, !m_full);
    chk("dout", dout, e_dout);
    chk("dvalid", dvalid, m_busy && en);
    chk("row", row, m_row);
    chk("done", done, m_done);
    if (dvalid) begin
      dv_cnt++; run++;
      if (run > maxrun) maxrun = run;
      sq.push_back(dout);
    end else begin
      run = 0;
    end
    if (!ready) rdy_low++;
    if (done) done_cnt++;
  endtask

  task automatic model_step();
    bit rdy0;
    if (!rst) return;
    rdy0 = !m_full;
    m_done = 0;
    if (!m_busy) begin
      if (m_full) begin
        m_busy = 1; m_word = m_hold; m_idx = W - 1; m_full = 0;
      end
    end else if (en) begin
      if (m_idx == LAST) begin
        m_row = (m_row + 1) % R;
        m_done = (m_row == 0);
        if (m_full) begin
          m_word = m_hold; m_idx = W - 1; m_full = 0;
        end else begin
          m_busy = 0;
        end
      end else begin
        m_idx--;
      end
    end
    if (load && rdy0) begin
      m_hold = din; m_full = 1;
    end
  endtask

  task automatic tick(input bit e, input bit l, input logic [W-1:0] d);
    @(negedge clk);
    en = e; load = l; din = d;
    #1;
    check_cycle();
    @(posedge clk);
    model_step();
  endtask

  task automatic run_idle();
    int g;
    g = 0;
    while ((m_busy || m_full) && g < 400) begin
      tick(1, 0, '0);
      g++;
    end
    chk("drain_timeout", (g < 400), 1);
    tick(1, 0, '0);
    tick(1, 0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; en = 0; load = 0;
    #1;
    model_reset();
    chk("rst_dout", dout, 0);
    chk("rst_ready", ready, 1);
    chk("rst_row", row, 0);
    chk("rst_dvalid", dvalid, 0);
    chk("rst_done", done, 0);
    tick(0, 0, '0);
    @(negedge clk);
    rst = 1;
    #1;
    check_cycle();
    @(posedge clk);
    model_step();
  endtask

  // Compare captured serial stream against the words' bits, MSB first, parity appended.
  task automatic cmp_stream(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int nw);
    bit exp[$];
    logic [W-1:0] w;
    int bad;
    for (int k = 0; k < nw; k++) begin
      w = (k == 0) ? a : b;
      for (int i = W - 1; i >= 0; i--) exp.push_back(w[i]);
`ifdef PISO_PARITY_EN
      exp.push_back(^w);
`endif
    end
    chk({nm, "_len"}, sq.size(), exp.size());
    bad = 0;
    for (int i = 0; i < exp.size() && i < sq.size(); i++) if (sq[i] != exp[i]) bad++;
    chk({nm, "_bits_wrong"}, bad, 0);
  endtask

  logic [W-1:0] words[R];
  logic [W-1:0] wa, wb, wc;

  initial begin
    model_reset();
    clear_stats();
    do_reset();
    repeat (3) tick(0, 0, '0);

    // Single word.
    clear_stats();
    wa = 70'h004023000000000000;
    tick(1, 1, wa);
    run_idle();
    chk("t1_bits", dv_cnt, WL);
    chk("t1_ready_low", rdy_low, 1);
    chk("t1_row", row, 1);
    cmp_stream("t1_stream", wa, wa, 1);

    // Full frame of 14 words.
    do_reset();
    clear_stats();
    words[0] = 70'h204016000000000000;
    words[R-1] = 70'h00C07D46072866091F;
    for (int i = 1; i < R - 1; i++) words[i] = rand_word();
    begin
      int k, g;
      k = 0; g = 0;
      while ((k < R || m_busy || m_full) && g < 3000) begin
        if (k < R && !m_full) begin
          tick(1, 1, words[k]);
          k++;
        end else begin
          tick(1, 0, '0);
        end
        g++;
      end
      chk("t2_timeout", (g < 3000), 1);
    end
    tick(1, 0, '0);
    tick(1, 0, '0);
    chk("t2_bits", dv_cnt, R * WL);
    chk("t2_done_pulses", done_cnt, 1);
    chk("t2_row", row, 0);

    // Back-to-back words with no gap.
    do_reset();
    clear_stats();
    wa = rand_word();
    wb = rand_word();
    tick(1, 1, wa);
    repeat (10) tick(1, 0, '0);
    tick(1, 1, wb);
    run_idle();
    chk("t3_run", maxrun, 2 * WL);
    cmp_stream("t3_stream", wa, wb, 2);

    // Enable dropped mid-word.
    clear_stats();
    wa = rand_word();
    tick(1, 1, wa);
    repeat (20) tick(1, 0, '0);
    repeat (5) tick(0, 0, '0);
    run_idle();
    chk("t4_bits", dv_cnt, WL);
    cmp_stream("t4_stream", wa, wa, 1);

    // Loads while the holder is full are dropped.
    clear_stats();
    wa = rand_word();
    wb = rand_word();
    wc = ~wb;
    tick(1, 1, wa);
    tick(1, 0, '0);
    tick(1, 0, '0);
    tick(1, 1, wb);
    repeat (5) tick(1, 1, wc);
    run_idle();
    cmp_stream("t5_stream", wa, wb, 2);

    // Reset in the middle of a word; the next word goes out whole.
    clear_stats();
    tick(1, 1, rand_word());
    begin
      int g;
      g = 0;
      while (!(m_busy && m_idx == W - 1 - 35) && g < 200) begin
        tick(1, 0, '0);
        g++;
      end
      chk("t6_timeout", (g < 200), 1);
    end
    do_reset();
    clear_stats();
    wa = 70'h0040234CCCC0000000;
    tick(1, 1, wa);
    run_idle();
    chk("t6_bits", dv_cnt, WL);
    cmp_stream("t6_stream", wa, wa, 1);
`ifdef PISO_PARITY_EN
    if (sq.size() == WL) chk("t6_parity", sq[W], 1);
`endif

    // Randomised traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), rand_word());
    end
    run_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/piso.md
# piso

Parallel-in serial-out transmitter for the FMA operand/result stream: accepts 70-bit words on a valid/ready interface and shifts them out MSB-first, one bit per enabled clock. It is the transmit end of the serial link whose receive end is `sipo`. Its serial output and enable connect straight to `sipo` `din`/`en`. A one-word holding register gives gap-free back-to-back streaming, and a row counter tracks position within a 14-word frame.

## Interface
- `WIDTH`, 70, bits per word.
- `ROWS`, 14, words per frame; `row` wraps after `ROWS-1`.
- `RW`, 4, width of `row`; must satisfy 2^RW ≥ ROWS.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  shift enable; the shifter advances only on edges where `en`=1.
- `load`  in  1  `din` is valid this cycle.
- `din`  in  WIDTH  parallel word.
- `ready`  out  1  holding register empty; `load` is accepted when `load`&`ready`.
- `dout`  out  1  current serial bit (MSB of the shift register).
- `dvalid`  out  1  `dout` is consumed on this edge (`state`=SHIFT & `en`).
- `row`  out  RW  index of the word currently shifting.
- `done`  out  1  one-cycle pulse when the last bit of row `ROWS-1` is consumed.

## Operation
- Storage:
  - `hold` (WIDTH) plus `hold_full` flag.
  - `shreg` (WIDTH).
  - bit counter `bcnt` (7 bits).
  - FSM with states IDLE and SHIFT, plus PARITY when configured.
- `ready` = !`hold_full`, combinational.
  - When `load`&`ready`: `hold` ← `din` and `hold_full` ← 1.
  - `load` while !`ready` is ignored; `hold` is never overwritten.
- IDLE:
  - If `hold_full`: `shreg` ← `hold`, `hold_full` ← 0, `bcnt` ← WIDTH-1, go to SHIFT.
  - This happens whether or not `en` is asserted.
- SHIFT: on each edge with `en`=1, `shreg` ← `shreg`<<1 and `bcnt` decrements.
- Last bit (`en`=1 and `bcnt`=0), without parity configured:
  - If `hold_full`, reload `shreg` from `hold` in the same edge and stay in SHIFT. There is no idle bit between words.
  - Otherwise go to IDLE.
  - Either way the word is complete: `row` increments, wrapping `ROWS-1`→0, and `done` pulses when the wrap occurs.
- `en`=0 in SHIFT: all state frozen, `dout` holds its value, `dvalid`=0.
- `dout` = `shreg[WIDTH-1]` in SHIFT and 0 in IDLE.
- Reset (async assert, any state):
  - `state`=IDLE, `shreg`=0, `hold`=0, `hold_full`=0, `bcnt`=0, `row`=0, `done`=0.
  - Outputs in reset: `dout`=0, `dvalid`=0, `ready`=1.
  - A partially sent word is discarded. Nothing resumes after reset is released.

## Timing
- `load` accepted at edge k → `hold` full after k.
- Shifter idle → transfer at edge k+1. `dout`=`din[69]` is valid during the cycle after k+1.
- With `en` held high, a word occupies exactly WIDTH consecutive `dvalid` cycles (WIDTH+1 with parity).
- `ready` rises in the cycle after the hold→shift transfer. A new word may therefore be loaded while the current one is shifting.
- Sustained streaming with `en`=1 needs each `load` to arrive at least 2 cycles before the current word's last bit. The transmitter then produces a continuous bit stream with no gaps.
- `done` is asserted in the cycle following the final consumed bit of the frame.

## Configuration
- `PISO_PARITY_EN` defined:
  - After bit 0, the FSM enters PARITY for one enabled cycle.
  - `dout` = XOR of the 70 transmitted bits (even parity) and `dvalid`=1.
  - The hold→shift reload, `row` increment and `done` pulse occur at the parity edge instead of the bit-0 edge.
  - `en`=0 in PARITY freezes the FSM.
- Undefined: no PARITY state; word length is exactly WIDTH. The stream is bit-compatible with `sipo`.

## Test plan
- Reset released, `load` 70'h004023000000000000 → `ready` drops for 1 cycle, then 70 `dvalid` bits equal `din[69]`…`din[0]`, then IDLE, `row`=1.
- Loopback into `sipo`: 14 words from 70'h204016000000000000 to 70'h00C07D46072866091F → `sipo` `dout` matches each word in order; `row` 0..13 then 0; one `done` pulse.
- Back-to-back: second word loaded 10 cycles into the first → 140 consecutive `dvalid` cycles, no gap, second word's MSB immediately after first's LSB.
- `en` dropped for 5 cycles mid-word → `dout` constant, `dvalid`=0; resumes with the next bit and no bit lost or duplicated.
- `load` while `ready`=0 with a distinct pattern → ignored; the transmitted words are only the accepted ones.
- `rst` asserted at bit 35 → `dout`=0, `ready`=1, `row`=0 immediately. The next loaded word is sent whole. With `PISO_PARITY_EN`, 71st bit = parity (70'h0040234CCCC0000000 → 1 (odd ones count)).
